// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU decode/issue/writeback stage.
package alu_issue_stage_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned CMND_W     = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RESULT_W   = 16;
  localparam int unsigned FLAG_W     = 3;

  localparam int unsigned NREGS_DEFAULT        = 8;
  localparam int unsigned CLEAR_CYCLES_DEFAULT = 8;

  // Instruction field bit positions
  localparam int unsigned CMND_HI     = 15;
  localparam int unsigned CMND_LO     = 12;
  localparam int unsigned RD_HI       = 11;
  localparam int unsigned RD_LO       = 9;
  localparam int unsigned IMM_SEL_BIT = 8;
  localparam int unsigned IMM_HI      = 7;
  localparam int unsigned IMM_LO      = 0;
  localparam int unsigned RS_HI       = 7;
  localparam int unsigned RS_LO       = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [CMND_W-1:0] cmnd;
    logic [IDX_W-1:0]  rd;
    logic              imm_sel;
    logic [IDX_W-1:0]  rs;
    logic [DATA_W-1:0] imm8;
  } instr_fields_t;

  // Split an instruction word into its fields; rs and imm8 overlap by design.
  function automatic instr_fields_t decode(input logic [INSTR_W-1:0] word);
    instr_fields_t f;
    f.cmnd    = word[CMND_HI:CMND_LO];
    f.rd      = word[RD_HI:RD_LO];
    f.imm_sel = word[IMM_SEL_BIT];
    f.rs      = word[RS_HI:RS_LO];
    f.imm8    = word[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile_8x8.sv
// 8x8 register file: one synchronous write port, three asynchronous reads, no reset.
module regfile_8x8
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  // Single write port; contents are only ever initialised by the owner's clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign rs_data  = mem[rs_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue into the ALU execute slot, forwarding, and result/flag writeback.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned NREGS        = NREGS_DEFAULT,
  parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instr,
  output logic [CMND_W-1:0]   cmnd,
  output logic [DATA_W-1:0]   primary_operand,
  output logic [DATA_W-1:0]   secondary_operand,
  output logic                ex_valid,
  input  logic [RESULT_W-1:0] result,
  input  logic [FLAG_W-1:0]   flags,
  output logic [FLAG_W-1:0]   flag_q,
  output logic [DATA_W-1:0]   hi_q,
  input  logic [IDX_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic [IDX_W-1:0]  ex_rd;

  instr_fields_t     fields;
  logic [DATA_W-1:0] rd_raw;
  logic [DATA_W-1:0] rs_raw;
  logic [DATA_W-1:0] rd_fwd;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] src_b;
  logic              accept;

  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign fields = decode(instr);
  assign accept = in_valid && in_ready;

  // Operand selection: the retiring result overrides a stale register read.
  always_comb begin
    rd_fwd = rd_raw;
    rs_fwd = rs_raw;
    if (ex_valid && (ex_rd == fields.rd)) begin
      rd_fwd = result[DATA_W-1:0];
    end
    if (ex_valid && (ex_rd == fields.rs)) begin
      rs_fwd = result[DATA_W-1:0];
    end
    src_b = fields.imm_sel ? fields.imm8 : rs_fwd;
  end

  // Register-file write mux: clear sweep or writeback; suppressed on a reset edge.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ex_rd;
    rf_wdata = result[DATA_W-1:0];
    if (state == ST_CLEAR) begin
      rf_waddr = clr_cnt;
      rf_wdata = '0;
    end
    if (reset) begin
      rf_we = (state == ST_CLEAR) || ex_valid;
    end
  end

  regfile_8x8 #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rd_addr  (fields.rd),
    .rd_data  (rd_raw),
    .rs_addr  (fields.rs),
    .rs_data  (rs_raw),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Control FSM, execute slot and architectural hi/flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= ST_CLEAR;
      clr_cnt           <= '0;
      in_ready          <= 1'b0;
      ex_valid          <= 1'b0;
      ex_rd             <= '0;
      cmnd              <= '0;
      primary_operand   <= '0;
      secondary_operand <= '0;
      flag_q            <= '0;
      hi_q              <= '0;
    end else begin
      if (ex_valid) begin
        hi_q   <= result[RESULT_W-1:DATA_W];
        flag_q <= flags;
      end
      case (state)
        ST_CLEAR: begin
          ex_valid <= 1'b0;
          clr_cnt  <= clr_cnt + IDX_W'(1);
          if (clr_cnt == IDX_W'(CLEAR_CYCLES - 1)) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ex_valid <= accept;
          if (accept) begin
            cmnd              <= fields.cmnd;
            primary_operand   <= rd_fwd;
            secondary_operand <= src_b;
            ex_rd             <= fields.rd;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          clr_cnt  <= '0;
          in_ready <= 1'b0;
          ex_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench: directed program against a transaction-level model of the stage.
module tb_alu_issue_stage;

  localparam logic [3:0] ALU_PASSTHROUGH = 4'h0;
  localparam logic [3:0] ALU_ADD         = 4'h1;
  localparam logic [3:0] ALU_MUL         = 4'h3;
  localparam int FLAG_NEG   = 2;
  localparam int CLEAR_LEN  = 8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [3:0]  cmnd;
  logic [7:0]  primary_operand;
  logic [7:0]  secondary_operand;
  logic        ex_valid;
  logic [15:0] result;
  logic [2:0]  flags;
  logic [2:0]  flag_q;
  logic [7:0]  hi_q;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.NREGS(8), .CLEAR_CYCLES(CLEAR_LEN)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instr             (instr),
    .cmnd              (cmnd),
    .primary_operand   (primary_operand),
    .secondary_operand (secondary_operand),
    .ex_valid          (ex_valid),
    .result            (result),
    .flags             (flags),
    .flag_q            (flag_q),
    .hi_q              (hi_q),
    .dbg_addr          (dbg_addr),
    .dbg_data          (dbg_data)
  );

  // Stand-in ALU: returns {flags{neg,carry,zero}, result[15:0]}.
  function automatic logic [18:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (c)
      ALU_PASSTHROUGH: r = {8'h00, b};
      ALU_ADD:         r = 16'(a) + 16'(b);
      ALU_MUL:         r = 16'(a) * 16'(b);
      default:         r = 16'h0000;
    endcase
    return {r[7], r[8], (r[7:0] == 8'h00), r};
  endfunction

  assign {flags, result} = alu_f(cmnd, primary_operand, secondary_operand);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known;
  bit          m_ready;
  bit          m_exv;
  int          m_clear_left;
  int          m_clr_idx;
  logic [3:0]  m_cmnd;
  logic [7:0]  m_a, m_b;
  logic [2:0]  m_rd;
  logic [2:0]  m_flag;
  logic [7:0]  m_hi;
  logic [7:0]  m_regs [8];
  bit          m_reg_known [8];
  logic [18:0] m_alu;

  initial begin
    m_known = 0;
    for (int i = 0; i < 8; i++) m_reg_known[i] = 0;
  end

  // Model: the retiring op lands first, then a newly accepted op reads architectural state.
  always @(posedge clk) begin
    m_alu = alu_f(m_cmnd, m_a, m_b);
    if (!reset) begin
      m_known = 1; m_ready = 0; m_exv = 0;
      m_clear_left = CLEAR_LEN; m_clr_idx = 0;
      m_cmnd = '0; m_a = '0; m_b = '0; m_rd = '0;
      m_flag = '0; m_hi = '0;
    end else if (m_known) begin
      if (m_exv) begin
        m_regs[m_rd] = m_alu[7:0];
        m_reg_known[m_rd] = 1;
        m_hi = m_alu[15:8];
        m_flag = m_alu[18:16];
      end
      if (m_clear_left > 0) begin
        m_regs[m_clr_idx] = 8'h00;
        m_reg_known[m_clr_idx] = 1;
        m_clr_idx++;
        m_clear_left--;
        m_exv = 0;
        if (m_clear_left == 0) m_ready = 1;
      end else if (m_ready && in_valid) begin
        m_cmnd = instr[15:12];
        m_rd   = instr[11:9];
        m_a    = m_regs[instr[11:9]];
        m_b    = instr[8] ? instr[7:0] : m_regs[instr[7:5]];
        m_exv  = 1;
      end else begin
        m_exv = 0;
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_known) begin
      check("in_ready", 16'(in_ready), 16'(m_ready));
      check("ex_valid", 16'(ex_valid), 16'(m_exv));
      check("cmnd", 16'(cmnd), 16'(m_cmnd));
      check("primary_operand", 16'(primary_operand), 16'(m_a));
      check("secondary_operand", 16'(secondary_operand), 16'(m_b));
      check("flag_q", 16'(flag_q), 16'(m_flag));
      check("hi_q", 16'(hi_q), 16'(m_hi));
      if (m_reg_known[dbg_addr]) check("dbg_data", 16'(dbg_data), 16'(m_regs[dbg_addr]));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] mk_imm(input logic [3:0] c, input logic [2:0] rd, input logic [7:0] imm);
    return {c, rd, 1'b1, imm};
  endfunction

  function automatic logic [15:0] mk_reg(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs);
    return {c, rd, 1'b0, rs, 5'b00000};
  endfunction

  task automatic drive(input logic [15:0] w);
    in_valid = 1'b1;
    instr    = w;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic peek(input logic [2:0] idx, input logic [7:0] exp, input string name);
    dbg_addr = idx; #1;
    check(name, 16'(dbg_data), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    reset = 1'b0; in_valid = 1'b0; instr = '0; dbg_addr = '0;

    // Reset release and clear sweep
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
      low_cnt++;
    end
    check("ready_low_cycles", 16'(low_cnt), 16'(CLEAR_LEN));
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) peek(3'(i), 8'h00, "swept_reg");
    check("flag_q_after_reset", 16'(flag_q), 16'h0);
    check("hi_q_after_reset", 16'(hi_q), 16'h0);

    // Immediate passthrough into R3
    drive(mk_imm(ALU_PASSTHROUGH, 3'd3, 8'h5A));
    check("imm_ex_valid", 16'(ex_valid), 16'h1);
    check("imm_secondary", 16'(secondary_operand), 16'h005A);
    idle(1);
    peek(3'd3, 8'h5A, "r3_imm");
    check("imm_flag_neg", 16'(flag_q[FLAG_NEG]), 16'h0);

    // Back-to-back forwarding R1 -> R2
    drive(mk_imm(ALU_PASSTHROUGH, 3'd1, 8'h91));
    check("fwd_ex_valid_1", 16'(ex_valid), 16'h1);
    drive(mk_reg(ALU_PASSTHROUGH, 3'd2, 3'd1));
    check("fwd_ex_valid_2", 16'(ex_valid), 16'h1);
    check("fwd_secondary", 16'(secondary_operand), 16'h0091);
    idle(1);
    peek(3'd2, 8'h91, "r2_fwd");
    check("fwd_flag_neg", 16'(flag_q[FLAG_NEG]), 16'h1);

    // Add then multiply (hi byte and carry)
    drive(mk_imm(ALU_ADD, 3'd3, 8'h10));
    check("add_primary", 16'(primary_operand), 16'h005A);
    drive(mk_imm(ALU_MUL, 3'd1, 8'h03));
    check("mul_primary", 16'(primary_operand), 16'h0091);

    // Idle hold: operands persist, only the pending mul retires
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("hold_ex_valid", 16'(ex_valid), 16'h0);
      check("hold_primary", 16'(primary_operand), 16'h0091);
      check("hold_secondary", 16'(secondary_operand), 16'h0003);
      check("hold_flag_q", 16'(flag_q), 16'b110);
      check("hold_hi_q", 16'(hi_q), 16'h0001);
    end
    peek(3'd3, 8'h6A, "r3_add");
    peek(3'd1, 8'hB3, "r1_mul");

    // Mid-operation reset drops the in-flight write
    drive(mk_imm(ALU_PASSTHROUGH, 3'd4, 8'hFF));
    check("midrst_ex_valid", 16'(ex_valid), 16'h1);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_ex_dropped", 16'(ex_valid), 16'h0);
    check("midrst_flag_q", 16'(flag_q), 16'h0);
    check("midrst_in_ready", 16'(in_ready), 16'h0);
    idle(CLEAR_LEN);
    check("midrst_ready_back", 16'(in_ready), 16'h1);
    peek(3'd4, 8'h00, "r4_never_written");
    peek(3'd1, 8'h00, "r1_reswept");

    // Self-reference R5 -> R5 right after its write
    drive(mk_imm(ALU_PASSTHROUGH, 3'd5, 8'h22));
    drive(mk_reg(ALU_PASSTHROUGH, 3'd5, 3'd5));
    check("selfref_secondary", 16'(secondary_operand), 16'h0022);
    check("selfref_primary", 16'(primary_operand), 16'h0022);
    idle(2);
    peek(3'd5, 8'h22, "r5_selfref");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue and writeback stage that drives the 8-bit ALU's command and operand inputs and retires its 16-bit result and 3-bit flags.

- Accepts 16-bit instruction words from fetch over a valid/ready handshake.
- Reads an 8×8 register file and forwards the in-flight ALU result.
- Registers `cmnd`/operands into the execute slot.
- Writes `result[7:0]`, `result[15:8]` and `flags` back one cycle later.

## Interface
Parameters:
- `NREGS`, 8, register count (fixed; 3-bit indices)
- `CLEAR_CYCLES`, 8, post-reset register-file clear sweep length

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low
- `in_valid`  in  1  fetch has an instruction
- `in_ready`  out  1  stage can accept this cycle
- `instr`  in  16  instruction word
- `cmnd`  out  4  ALU command, registered
- `primary_operand`  out  8  ALU operand A, registered
- `secondary_operand`  out  8  ALU operand B, registered
- `ex_valid`  out  1  execute slot holds a live instruction
- `result`  in  16  ALU result, combinational from ALU
- `flags`  in  3  ALU flags {neg, carry, zero} per constants.v
- `flag_q`  out  3  architectural flag register
- `hi_q`  out  8  high-byte register (`result[15:8]` of last retired op)
- `dbg_addr`  in  3  register-file debug read index
- `dbg_data`  out  8  asynchronous read of R[`dbg_addr`]

## Operation
- **Instruction fields:**
  - `[15:12]` cmnd: passed through unchanged; encodings from constants.v.
  - `[11:9]` rd.
  - `[8]` imm_sel.
  - imm_sel=1: `[7:0]` imm8.
  - imm_sel=0: `[7:5]` rs; `[4:0]` ignored.
- **FSM, two states:**
  - CLEAR: `in_ready`=0; a 3-bit counter writes 0 to R[counter] each cycle; after `CLEAR_CYCLES` writes, go to RUN.
  - RUN: `in_ready`=1. There are no other stall sources.
- **Accept:** `in_valid && in_ready` at an edge. On that edge:
  - `cmnd`←`instr[15:12]`
  - `primary_operand`←fwd(rd)
  - `secondary_operand`←imm_sel ? imm8 : fwd(rs)
  - `ex_rd`←rd
  - `ex_valid`←1
- **No accept:** `ex_valid`←0; `cmnd`/operand outputs hold their values.
- **Forwarding:** fwd(i) = (`ex_valid` && `ex_rd`==i) ? `result[7:0]` : R[i]. This also applies when rd==rs.
- **Writeback:** at every edge with `ex_valid`=1:
  - R[`ex_rd`]←`result[7:0]`
  - `hi_q`←`result[15:8]`
  - `flag_q`←`flags`
- **Write collision:** a CLEAR write and a writeback cannot coincide, because `ex_valid`=0 throughout CLEAR.
- **`dbg_data`:** reflects register contents before the current edge's write.
- **Width rules:** no sign extension. imm8 is used as-is. The upper result byte goes only to `hi_q`.

## Timing
- **Reset** (`reset`=0 at an edge):
  - state→CLEAR, counter→0
  - `ex_valid`, `cmnd`, both operands, `flag_q`, `hi_q` → 0
  - `in_ready`=0
  - Register contents are not reset directly; the CLEAR sweep zeroes them.
- **Reset mid-operation:** the in-flight execute instruction is dropped with no writeback. The sweep restarts at R0.
- **After reset release:** `in_ready` is low for exactly `CLEAR_CYCLES` cycles, then high.
- **Latency:**
  - Instruction accepted at edge k → on ALU inputs during cycle k..k+1.
  - Writeback at edge k+1.
  - Back-to-back dependent instructions: zero bubbles via forwarding.
- **Throughput:** 1 instruction/cycle in RUN.

## Structure
- **Shared package** (alongside constants.v):
  - instruction field bit positions
  - state encoding {CLEAR, RUN}
  - `CLEAR_CYCLES`
- **ALU command and flag-index macros:** remain in constants.v; this block does not redefine them.
- **Sub-module `regfile_8x8`:**
  - one synchronous write port
  - three asynchronous read ports (rd, rs, dbg)
  - no reset

## Test plan
Bench instantiates this block with the real `alu`.
- **Reset release:** hold `reset`=0 for 3 cycles, then release → `in_ready`=0 for exactly 8 cycles, then 1; `dbg_data`=0x00 for all 8 indices; `flag_q`=0, `hi_q`=0.
- **Immediate passthrough:** ALU_PASSTHROUGH, rd=3, imm8=0x5A → `ex_valid`=1 next cycle with `secondary_operand`=0x5A; after writeback, R3=0x5A and `flag_q[NEG]`=0.
- **Back-to-back forwarding:** passthrough imm 0x91→R1, then immediately passthrough rs=R1→R2 → R2=0x91, `flag_q[NEG]`=1, no bubble (`ex_valid` high 2 consecutive cycles).
- **Idle hold:** `in_valid`=0 for 4 cycles after an op → `ex_valid`=0, operand outputs unchanged, no register or flag change.
- **Mid-operation reset:** accept passthrough imm 0xFF→R4, assert `reset` on the next edge → R4 never written (reads 0x00 after sweep); `flag_q`=0.
- **Self-reference:** R5=0x22, then passthrough rs=5→rd=5 issued back-to-back after the write → forwarded 0x22 observed on `secondary_operand`; R5=0x22.
